// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM from one shared period counter, double-buffered duty/period updates.
// Optional macro PWM_FADE_EN: duty ramps toward the staged value by FADE_STEP per period.
module pwm_bank #(
   parameter int CHANNELS       = 16,
   parameter int CNT_W          = 27,
   parameter int PERIOD_DEFAULT = 100_000_000,
   parameter int DUTY_DEFAULT   = 50_000_000,
   parameter int FADE_STEP      = 1,
   localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] en,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [CH_W-1:0]     wr_chan,
   input  logic [CNT_W-1:0]    wr_duty,
   input  logic                period_we,
   input  logic [CNT_W-1:0]    period_in,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                period_start
);

   typedef enum logic [0:0] {ST_HOLD = 1'b0, ST_RUN = 1'b1} state_t;

   localparam logic [CNT_W-1:0] ZERO_C     = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] ONE_C      = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(PERIOD_DEFAULT);
   localparam logic [CNT_W-1:0] DUTY_RST   = CNT_W'(DUTY_DEFAULT);
   localparam state_t           STATE_RST  = (PERIOD_DEFAULT == 0) ? ST_HOLD : ST_RUN;

`ifdef PWM_FADE_EN
   localparam logic [CNT_W-1:0] STEP_C = CNT_W'(FADE_STEP);

   function automatic logic [CNT_W-1:0] fade_next(input logic [CNT_W-1:0] cur,
                                                  input logic [CNT_W-1:0] tgt);
      logic [CNT_W-1:0] res;
      if (cur < tgt) begin
         res = ((tgt - cur) > STEP_C) ? (cur + STEP_C) : tgt;
      end else begin
         res = ((cur - tgt) > STEP_C) ? (cur - STEP_C) : tgt;
      end
      return res;
   endfunction
`endif

   state_t                state_r, next_state_s;
   logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
   logic [CNT_W-1:0]      period_act_r, period_act_nxt_s;
   logic [CNT_W-1:0]      period_shd_r, period_shd_nxt_s;
   logic [CNT_W-1:0]      duty_act_r [CHANNELS];
   logic [CNT_W-1:0]      duty_act_nxt_s [CHANNELS];
   logic [CNT_W-1:0]      duty_shd_r [CHANNELS];
   logic [CNT_W-1:0]      duty_shd_nxt_s [CHANNELS];
   logic [CHANNELS-1:0]   pend_r, pend_nxt_s;
   logic [CHANNELS-1:0]   pwm_out_r, pwm_nxt_s;
   logic                  period_start_r, period_start_nxt_s;
   logic                  run_s, wrap_s, apply_s, wr_fire_s;

   assign run_s     = (state_r == ST_RUN);
   assign wrap_s    = run_s && (cnt_r == (period_act_r - ONE_C));
   // HOLD has no wrap to wait for, so staged values are taken every cycle there.
   assign apply_s   = !run_s || wrap_s;
   assign wr_fire_s = wr_valid && !wrap_s;

   assign wr_ready     = !wrap_s;
   assign pwm_out      = pwm_out_r;
   assign period_start = period_start_r;

   // FSM next state: leave or enter HOLD only when a staged period is applied
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_HOLD: begin
            if (period_shd_r != ZERO_C) next_state_s = ST_RUN;
            else                        next_state_s = ST_HOLD;
         end
         ST_RUN: begin
            if (wrap_s && (period_shd_r == ZERO_C)) next_state_s = ST_HOLD;
            else                                    next_state_s = ST_RUN;
         end
         default: next_state_s = ST_HOLD;
      endcase
   end

   // Counter, period buffers and output decode
   always_comb begin
      cnt_nxt_s          = ZERO_C;
      period_act_nxt_s   = period_act_r;
      period_shd_nxt_s   = period_shd_r;
      period_start_nxt_s = run_s && (cnt_r == ZERO_C);
      if (run_s && !wrap_s) cnt_nxt_s = cnt_r + ONE_C;
      else                  cnt_nxt_s = ZERO_C;
      if (apply_s) period_act_nxt_s = period_shd_r;
      else         period_act_nxt_s = period_act_r;
      if (period_we) period_shd_nxt_s = period_in;
      else           period_shd_nxt_s = period_shd_r;
      for (int i = 0; i < CHANNELS; i++) begin
         pwm_nxt_s[i] = en[i] & run_s & (cnt_r < duty_act_r[i]);
      end
   end

   // Per-channel duty buffers; out-of-range wr_chan matches no channel and is dropped
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         duty_act_nxt_s[i] = duty_act_r[i];
         duty_shd_nxt_s[i] = duty_shd_r[i];
         pend_nxt_s[i]     = pend_r[i];
         if (apply_s && pend_r[i]) begin
`ifdef PWM_FADE_EN
            duty_act_nxt_s[i] = fade_next(duty_act_r[i], duty_shd_r[i]);
            pend_nxt_s[i]     = (duty_act_nxt_s[i] != duty_shd_r[i]);
`else
            duty_act_nxt_s[i] = duty_shd_r[i];
            pend_nxt_s[i]     = 1'b0;
`endif
         end else begin
            duty_act_nxt_s[i] = duty_act_r[i];
         end
         if (wr_fire_s && (wr_chan == CH_W'(i))) begin
            duty_shd_nxt_s[i] = wr_duty;
            pend_nxt_s[i]     = 1'b1;
         end else begin
            duty_shd_nxt_s[i] = duty_shd_nxt_s[i];
         end
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= STATE_RST;
         cnt_r          <= ZERO_C;
         period_act_r   <= PERIOD_RST;
         period_shd_r   <= PERIOD_RST;
         pend_r         <= {CHANNELS{1'b0}};
         pwm_out_r      <= {CHANNELS{1'b0}};
         period_start_r <= 1'b0;
         for (int i = 0; i < CHANNELS; i++) begin
            duty_act_r[i] <= DUTY_RST;
            duty_shd_r[i] <= DUTY_RST;
         end
      end else begin
         state_r        <= next_state_s;
         cnt_r          <= cnt_nxt_s;
         period_act_r   <= period_act_nxt_s;
         period_shd_r   <= period_shd_nxt_s;
         pend_r         <= pend_nxt_s;
         pwm_out_r      <= pwm_nxt_s;
         period_start_r <= period_start_nxt_s;
         for (int i = 0; i < CHANNELS; i++) begin
            duty_act_r[i] <= duty_act_nxt_s[i];
            duty_shd_r[i] <= duty_shd_nxt_s[i];
         end
      end
   end

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: scenario tasks for pwm_bank with a per-cycle scoreboard of expected outputs.
module tb_pwm_bank;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] en = 4'hF;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic [1:0] wr_chan = 2'd0;
   logic [7:0] wr_duty = 8'd0;
   logic       period_we = 1'b0;
   logic [7:0] period_in = 8'd0;
   logic [3:0] pwm_out;
   logic       period_start;

   int vectors = 0;
   int miscompares = 0;
   logic [4:0] sb_q[$];
   logic [4:0] exp_v;

   pwm_bank #(
      .CHANNELS(4), .CNT_W(8), .PERIOD_DEFAULT(10), .DUTY_DEFAULT(5), .FADE_STEP(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_chan(wr_chan), .wr_duty(wr_duty), .period_we(period_we), .period_in(period_in),
      .pwm_out(pwm_out), .period_start(period_start)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1);
   end

   // Reference model of the behaviour, one entry of {pwm_out, period_start} per clock.
   int       m_cnt, m_pa, m_ps;
   int       m_da [4];
   int       m_ds [4];
   logic [3:0] m_pend;
   logic [3:0] m_ep;
   logic     m_run, m_wrap, m_apply;

   function automatic int m_step(input int cur, input int tgt);
`ifdef PWM_FADE_EN
      if (cur < tgt) return cur + 1;
      else if (cur > tgt) return cur - 1;
      else return cur;
`else
      return tgt + 0 * cur;
`endif
   endfunction

   always_comb begin
      m_run   = (m_pa != 0);
      m_wrap  = m_run && (m_cnt == m_pa - 1);
      m_apply = !m_run || m_wrap;
      for (int i = 0; i < 4; i++) m_ep[i] = en[i] && m_run && (m_cnt < m_da[i]);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  <= 0;
         m_pa   <= 10;
         m_ps   <= 10;
         m_pend <= 4'h0;
         for (int i = 0; i < 4; i++) begin
            m_da[i] <= 5;
            m_ds[i] <= 5;
         end
         sb_q.delete();
      end else begin
         sb_q.push_back({m_ep, m_run && (m_cnt == 0)});
         m_cnt <= m_apply ? 0 : m_cnt + 1;
         if (m_apply) m_pa <= m_ps;
         if (period_we) m_ps <= int'(period_in);
         for (int i = 0; i < 4; i++) begin
            if (m_apply && m_pend[i]) begin
               m_da[i]   <= m_step(m_da[i], m_ds[i]);
               m_pend[i] <= (m_step(m_da[i], m_ds[i]) != m_ds[i]);
            end
            if (wr_valid && !m_wrap && (int'(wr_chan) == i)) begin
               m_ds[i]   <= int'(wr_duty);
               m_pend[i] <= 1'b1;
            end
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (pwm_out !== 4'h0 || period_start !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_out: got %b/%b, expected 0000/0", pwm_out, period_start);
      end
      vectors++;
      if (wr_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready: got %b, expected 1", wr_ready);
      end
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         exp_v = sb_q.pop_front();
         vectors++;
         if ({pwm_out, period_start} !== exp_v) begin
            miscompares++;
            $display("FAIL sb_reset: got %b, expected %b", {pwm_out, period_start}, exp_v);
         end
         vectors++;
         if (pwm_out !== (((k % 10) < 5) ? 4'hF : 4'h0) || period_start !== ((k % 10) == 0)) begin
            miscompares++;
            $display("FAIL reset_pattern k=%0d: got %b/%b", k, pwm_out, period_start);
         end
      end
   endtask

   task automatic test_write_mid();
      int hi_old, hi2, hi0;
      hi_old = 0; hi2 = 0; hi0 = 0;
      sb_q.delete();
      for (int g = 0; g < 40; g++) begin
         if (m_cnt == 3) break;
         @(posedge clk); #1; exp_v = sb_q.pop_front();
      end
      vectors++;
      if (m_cnt != 3) begin miscompares++; $display("FAIL wait_cnt3: got %0d, expected 3", m_cnt); end
      wr_valid = 1'b1; wr_chan = 2'd2; wr_duty = 8'd8;
      @(posedge clk); #1; exp_v = sb_q.pop_front();
      wr_valid = 1'b0;
      for (int g = 0; g < 30; g++) begin
         @(posedge clk); #1; exp_v = sb_q.pop_front();
         if (period_start === 1'b1) break;
         hi_old += int'(pwm_out[2]);
      end
      vectors++;
      if (period_start !== 1'b1) begin miscompares++; $display("FAIL wr_timeout: got 0, expected period_start"); end
      vectors++;
      if (hi_old != 1) begin miscompares++; $display("FAIL ch2_old_tail: got %0d, expected 1", hi_old); end
      for (int k = 0; k < 10; k++) begin
         if (k > 0) begin @(posedge clk); #1; exp_v = sb_q.pop_front(); end
         vectors++;
         if ({pwm_out, period_start} !== exp_v) begin
            miscompares++;
            $display("FAIL sb_write: got %b, expected %b", {pwm_out, period_start}, exp_v);
         end
         hi2 += int'(pwm_out[2]);
         hi0 += int'(pwm_out[0]);
      end
      vectors++;
      if (hi2 != 8) begin miscompares++; $display("FAIL ch2_high: got %0d, expected 8", hi2); end
      vectors++;
      if (hi0 != 5) begin miscompares++; $display("FAIL ch0_high: got %0d, expected 5", hi0); end
   endtask

   task automatic test_wrap_write();
      int hi_a, hi_b;
      hi_a = 0; hi_b = 0;
      sb_q.delete();
      for (int g = 0; g < 40; g++) begin
         if (m_cnt == 9) break;
         @(posedge clk); #1; exp_v = sb_q.pop_front();
      end
      vectors++;
      if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL ready_wrap: got %b, expected 0", wr_ready); end
      wr_valid = 1'b1; wr_chan = 2'd1; wr_duty = 8'd2;
      @(posedge clk); #1; exp_v = sb_q.pop_front();
      vectors++;
      if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after: got %b, expected 1", wr_ready); end
      @(posedge clk); #1; exp_v = sb_q.pop_front();
      wr_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (k > 0) begin @(posedge clk); #1; exp_v = sb_q.pop_front(); end
         vectors++;
         if ({pwm_out, period_start} !== exp_v || period_start !== ((k % 10) == 0)) begin
            miscompares++;
            $display("FAIL sb_wrap k=%0d: got %b, expected %b", k, {pwm_out, period_start}, exp_v);
         end
         if (k < 10) hi_a += int'(pwm_out[1]);
         else        hi_b += int'(pwm_out[1]);
      end
      vectors++;
      if (hi_a != 5 || hi_b != 2) begin
         miscompares++;
         $display("FAIL ch1_wrap_write: got %0d then %0d, expected 5 then 2", hi_a, hi_b);
      end
   endtask

   task automatic test_extremes();
      int hi0, hi1;
      hi0 = 0; hi1 = 0;
      sb_q.delete();
      for (int g = 0; g < 40; g++) begin
         if (m_cnt == 2) break;
         @(posedge clk); #1; exp_v = sb_q.pop_front();
      end
      wr_valid = 1'b1; wr_chan = 2'd0; wr_duty = 8'd0;
      @(posedge clk); #1; exp_v = sb_q.pop_front();
      wr_chan = 2'd1; wr_duty = 8'd200;
      @(posedge clk); #1; exp_v = sb_q.pop_front();
      wr_valid = 1'b0;
      for (int g = 0; g < 30; g++) begin
         @(posedge clk); #1; exp_v = sb_q.pop_front();
         if (period_start === 1'b1) break;
      end
      for (int k = 0; k < 10; k++) begin
         if (k > 0) begin @(posedge clk); #1; exp_v = sb_q.pop_front(); end
         vectors++;
         if ({pwm_out, period_start} !== exp_v) begin
            miscompares++;
            $display("FAIL sb_extreme: got %b, expected %b", {pwm_out, period_start}, exp_v);
         end
         hi0 += int'(pwm_out[0]);
         hi1 += int'(pwm_out[1]);
      end
      vectors++;
      if (hi0 != 0 || hi1 != 10) begin
         miscompares++;
         $display("FAIL duty_saturate: got ch0=%0d ch1=%0d, expected 0 and 10", hi0, hi1);
      end
      en = 4'b1101;
      @(posedge clk); #1; exp_v = sb_q.pop_front();
      vectors++;
      if (pwm_out !== 4'b1100) begin
         miscompares++;
         $display("FAIL en_mask: got %b, expected 1100", pwm_out);
      end
      en = 4'hF;
   endtask

   task automatic test_period();
      sb_q.delete();
      for (int g = 0; g < 40; g++) begin
         if (m_cnt == 2) break;
         @(posedge clk); #1; exp_v = sb_q.pop_front();
      end
      period_we = 1'b1; period_in = 8'd0;
      @(posedge clk); #1; exp_v = sb_q.pop_front();
      period_we = 1'b0;
      for (int g = 0; g < 20; g++) begin
         if (m_pa == 0) break;
         @(posedge clk); #1; exp_v = sb_q.pop_front();
      end
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1; exp_v = sb_q.pop_front();
         vectors++;
         if ({pwm_out, period_start} !== 5'b00000 || exp_v !== 5'b00000) begin
            miscompares++;
            $display("FAIL hold_quiet: got %b, expected %b", {pwm_out, period_start}, exp_v);
         end
      end
      period_we = 1'b1; period_in = 8'd4;
      @(posedge clk); #1; exp_v = sb_q.pop_front();
      period_we = 1'b0;
      for (int g = 0; g < 10; g++) begin
         @(posedge clk); #1; exp_v = sb_q.pop_front();
         if (period_start === 1'b1) break;
      end
      for (int k = 0; k < 8; k++) begin
         if (k > 0) begin @(posedge clk); #1; exp_v = sb_q.pop_front(); end
         vectors++;
         if (pwm_out !== 4'b1110 || period_start !== ((k % 4) == 0) ||
             {pwm_out, period_start} !== exp_v) begin
            miscompares++;
            $display("FAIL period4 k=%0d: got %b, expected %b", k, {pwm_out, period_start}, exp_v);
         end
      end
   endtask

   task automatic test_reset_mid();
      sb_q.delete();
      for (int g = 0; g < 20; g++) begin
         if (m_cnt == 1) break;
         @(posedge clk); #1; exp_v = sb_q.pop_front();
      end
      wr_valid = 1'b1; wr_chan = 2'd3; wr_duty = 8'd1;
      @(posedge clk); #1;
      wr_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (pwm_out !== 4'h0 || period_start !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid_out: got %b/%b, expected 0000/0", pwm_out, period_start);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      sb_q.delete();
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1; exp_v = sb_q.pop_front();
         vectors++;
         if (pwm_out !== ((k < 5) ? 4'hF : 4'h0) || period_start !== (k == 0) ||
             {pwm_out, period_start} !== exp_v) begin
            miscompares++;
            $display("FAIL reset_mid_pattern k=%0d: got %b, expected %b", k, {pwm_out, period_start}, exp_v);
         end
      end
   endtask

`ifdef PWM_FADE_EN
   task automatic test_fade();
      int hi [3];
      int hr;
      hi[0] = 0; hi[1] = 0; hi[2] = 0; hr = 0;
      sb_q.delete();
      for (int g = 0; g < 40; g++) begin
         if (m_cnt == 3) break;
         @(posedge clk); #1; exp_v = sb_q.pop_front();
      end
      wr_valid = 1'b1; wr_chan = 2'd3; wr_duty = 8'd8;
      @(posedge clk); #1; exp_v = sb_q.pop_front();
      wr_valid = 1'b0;
      for (int g = 0; g < 30; g++) begin
         @(posedge clk); #1; exp_v = sb_q.pop_front();
         if (period_start === 1'b1) break;
      end
      for (int k = 0; k < 30; k++) begin
         if (k > 0) begin @(posedge clk); #1; exp_v = sb_q.pop_front(); end
         vectors++;
         if ({pwm_out, period_start} !== exp_v) begin
            miscompares++;
            $display("FAIL sb_fade: got %b, expected %b", {pwm_out, period_start}, exp_v);
         end
         hi[k / 10] += int'(pwm_out[3]);
      end
      vectors++;
      if (hi[0] != 6 || hi[1] != 7 || hi[2] != 8) begin
         miscompares++;
         $display("FAIL fade_ramp: got %0d,%0d,%0d, expected 6,7,8", hi[0], hi[1], hi[2]);
      end
      for (int g = 0; g < 40; g++) begin
         if (m_cnt == 3) break;
         @(posedge clk); #1; exp_v = sb_q.pop_front();
      end
      wr_valid = 1'b1; wr_duty = 8'd12;
      @(posedge clk); #1;
      wr_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         hr += int'(pwm_out[3]);
      end
      vectors++;
      if (hr != 5) begin miscompares++; $display("FAIL fade_reset: got %0d, expected 5", hr); end
   endtask
`endif

   initial begin
      test_reset();
      test_write_mid();
      test_wrap_write();
      test_extremes();
      test_period();
      test_reset_mid();
`ifdef PWM_FADE_EN
      test_fade();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
